// File: rtl/div_sqrt_issue_queue_pkg.sv
// Shared types for the div/sqrt issue queue: operation, FSM states, request payload and flags.
// The DRAIN state exists only when DIV_SQRT_KILL_EN is defined.
package fpu_defs_div_sqrt;

  localparam int C_RM = 3;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_SQRT = 1'b1
  } div_sqrt_op_e;

`ifdef DIV_SQRT_KILL_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } issue_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } issue_state_e;
`endif

  // Tag width is a parameter of the queue, so the tag is attached where the entry type is built.
  typedef struct packed {
    div_sqrt_op_e      op;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [C_RM-1:0]   rm;
  } div_sqrt_req_t;

  typedef struct packed {
    logic of;
    logic uf;
    logic dz;
  } div_sqrt_flags_t;

endpackage

// File: rtl/div_sqrt_req_fifo.sv
// Circular request buffer with count-based full/empty; pointers wrap explicitly at DEPTH.
module div_sqrt_req_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [7:0]
) (
  input  logic   Clk_CI,
  input  logic   Rst_RBI,
  input  logic   Flush_SI,
  input  logic   Push_SI,
  input  entry_t Data_DI,
  input  logic   Pop_SI,
  output entry_t Data_DO,
  output logic   Full_SO,
  output logic   Empty_SO
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  assign Full_SO  = (cnt_q == DepthCnt);
  assign Empty_SO = (cnt_q == '0);
  assign push_ok  = Push_SI && !Full_SO;
  assign pop_ok   = Pop_SI && !Empty_SO;
  assign Data_DO  = mem_q[rd_ptr_q];

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (Flush_SI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge Clk_CI) begin
    if (push_ok) mem_q[wr_ptr_q] <= Data_DI;
  end

endmodule

// File: rtl/div_sqrt_issue_queue.sv
// Request front-end for the shared div/sqrt unit: FIFO, single-op launch FSM, tagged result slot.
// Defining DIV_SQRT_KILL_EN adds the Kill_SI flush port and a DRAIN state.
module div_sqrt_issue_queue
  import fpu_defs_div_sqrt::*;
#(
  parameter int DEPTH     = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
`ifdef DIV_SQRT_KILL_EN
  input  logic                 Kill_SI,
`endif
  input  logic                 In_valid_SI,
  output logic                 In_ready_SO,
  input  logic                 In_op_SI,
  input  logic [31:0]          In_operand_a_DI,
  input  logic [31:0]          In_operand_b_DI,
  input  logic [C_RM-1:0]      In_rm_SI,
  input  logic [TAG_WIDTH-1:0] In_tag_DI,
  output logic                 Div_start_SO,
  output logic                 Sqrt_start_SO,
  output logic [31:0]          Operand_a_DO,
  output logic [31:0]          Operand_b_DO,
  output logic [C_RM-1:0]      RM_SO,
  input  logic                 Unit_ready_SI,
  input  logic                 Unit_done_SI,
  input  logic [31:0]          Unit_result_DI,
  input  logic                 Unit_OF_SI,
  input  logic                 Unit_UF_SI,
  input  logic                 Unit_div_zero_SI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [31:0]          Out_result_DO,
  output logic [2:0]           Out_flags_DO,
  output logic [TAG_WIDTH-1:0] Out_tag_DO
);

  typedef struct packed {
    div_sqrt_req_t        req;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t               in_entry, head_entry, launch_q;
  issue_state_e         state_q, state_d;
  logic                 fifo_full, fifo_empty;
  logic                 kill, push, pop, capture, out_free, can_issue;
  logic                 out_valid_q;
  logic [31:0]          out_result_q;
  div_sqrt_flags_t      out_flags_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

`ifdef DIV_SQRT_KILL_EN
  assign kill = Kill_SI;
`else
  assign kill = 1'b0;
`endif

  assign in_entry = '{req: '{op: div_sqrt_op_e'(In_op_SI), a: In_operand_a_DI,
                             b: In_operand_b_DI, rm: In_rm_SI},
                      tag: In_tag_DI};

  assign In_ready_SO = !fifo_full && !kill;
  assign push        = In_valid_SI && In_ready_SO;

  // Issue only when the slot will be free by the time done can return.
  assign out_free  = !out_valid_q || Out_ready_SI;
  assign can_issue = !fifo_empty && Unit_ready_SI && out_free && !kill;

  div_sqrt_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) i_req_fifo (
    .Clk_CI   (Clk_CI),
    .Rst_RBI  (Rst_RBI),
    .Flush_SI (kill),
    .Push_SI  (push),
    .Data_DI  (in_entry),
    .Pop_SI   (pop),
    .Data_DO  (head_entry),
    .Full_SO  (fifo_full),
    .Empty_SO (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_issue) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_BUSY;
      ST_BUSY: begin
        if (Unit_done_SI) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef DIV_SQRT_KILL_EN
      ST_DRAIN: begin
        if (Unit_done_SI) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef DIV_SQRT_KILL_EN
    // A done arriving in the kill cycle is already the abandoned result, so skip DRAIN.
    if (kill && (state_q == ST_START || state_q == ST_BUSY)) begin
      capture = 1'b0;
      state_d = (state_q == ST_BUSY && Unit_done_SI) ? ST_IDLE : ST_DRAIN;
    end
`endif
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= ST_IDLE;
      launch_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) launch_q <= head_entry;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      out_result_q <= Unit_result_DI;
      out_flags_q  <= '{of: Unit_OF_SI, uf: Unit_UF_SI, dz: Unit_div_zero_SI};
      out_tag_q    <= launch_q.tag;
    end else if (out_valid_q && Out_ready_SI) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
    end
  end

  assign Div_start_SO  = (state_q == ST_START) && (launch_q.req.op == OP_DIV);
  assign Sqrt_start_SO = (state_q == ST_START) && (launch_q.req.op == OP_SQRT);
  assign Operand_a_DO  = launch_q.req.a;
  assign Operand_b_DO  = launch_q.req.b;
  assign RM_SO         = launch_q.req.rm;
  assign Out_valid_SO  = out_valid_q;
  assign Out_result_DO = out_result_q;
  assign Out_flags_DO  = out_flags_q;
  assign Out_tag_DO    = out_tag_q;

endmodule

// File: tb/tb_div_sqrt_issue_queue.sv
// Directed, scoreboard-based bench for div_sqrt_issue_queue with a behavioural div/sqrt unit model.
// Define DIV_SQRT_KILL_EN to also exercise the kill/drain path.
module tb_div_sqrt_issue_queue;
  import fpu_defs_div_sqrt::*;

  localparam int DEPTH     = 2;
  localparam int TAG_WIDTH = 4;

  typedef struct packed {
    logic [31:0]          result;
    logic [2:0]           flags;
    logic [TAG_WIDTH-1:0] tag;
  } exp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic                 inValid, inReady, inOp;
  logic [31:0]          inA, inB;
  logic [C_RM-1:0]      inRm;
  logic [TAG_WIDTH-1:0] inTag;
  logic                 divStart, sqrtStart;
  logic [31:0]          opA, opB;
  logic [C_RM-1:0]      rmOut;
  logic                 unitReady, unitDone, unitOf, unitUf, unitDz;
  logic [31:0]          unitResult;
  logic                 outValid, outReady;
  logic [31:0]          outResult;
  logic [2:0]           outFlags;
  logic [TAG_WIDTH-1:0] outTag;
`ifdef DIV_SQRT_KILL_EN
  logic                 kill;
`endif

  logic        modelDone, modelOf, modelUf, modelDz, modelBusy, latOp, lateDone;
  logic [31:0] modelResult, latA, latB;
  logic [C_RM-1:0] latRm;
  int          modelCnt, unitLatency, divStarts, sqrtStarts;
  int          assertCount, failCount;
  exp_t        expQ[$];

  assign unitDone   = modelDone | lateDone;
  assign unitResult = modelDone ? modelResult : 32'hDEADBEEF;
  assign unitOf     = modelDone ? modelOf : lateDone;
  assign unitUf     = modelDone ? modelUf : lateDone;
  assign unitDz     = modelDone ? modelDz : lateDone;

  div_sqrt_issue_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rstN),
`ifdef DIV_SQRT_KILL_EN
    .Kill_SI          (kill),
`endif
    .In_valid_SI      (inValid),
    .In_ready_SO      (inReady),
    .In_op_SI         (inOp),
    .In_operand_a_DI  (inA),
    .In_operand_b_DI  (inB),
    .In_rm_SI         (inRm),
    .In_tag_DI        (inTag),
    .Div_start_SO     (divStart),
    .Sqrt_start_SO    (sqrtStart),
    .Operand_a_DO     (opA),
    .Operand_b_DO     (opB),
    .RM_SO            (rmOut),
    .Unit_ready_SI    (unitReady),
    .Unit_done_SI     (unitDone),
    .Unit_result_DI   (unitResult),
    .Unit_OF_SI       (unitOf),
    .Unit_UF_SI       (unitUf),
    .Unit_div_zero_SI (unitDz),
    .Out_valid_SO     (outValid),
    .Out_ready_SI     (outReady),
    .Out_result_DO    (outResult),
    .Out_flags_DO     (outFlags),
    .Out_tag_DO       (outTag)
  );

  // Toy arithmetic: result depends on op, both operands and rounding mode so misrouting shows.
  function automatic logic [34:0] unitModel(input logic op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [C_RM-1:0] rm);
    logic [31:0] r;
    logic        of, uf, dz;
    if (op) begin
      r  = (a >> 1) + 32'h1FC00000;
      of = 1'b0;
      uf = 1'b0;
      dz = 1'b0;
    end else begin
      r  = (b == 32'h3F800000) ? a : (a ^ b);
      of = (a[30:23] == 8'hFE);
      uf = (a[30:23] == 8'h01);
      dz = (b[30:0] == 31'd0);
    end
    r = r ^ {29'd0, rm};
    return {r, of, uf, dz};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic [C_RM-1:0] rm, input logic [TAG_WIDTH-1:0] tag,
                               output int waited, output logic startAtAccept);
    logic        accepted;
    logic [34:0] m;
    exp_t        e;
    inValid = 1'b1;
    inOp    = op;
    inA     = a;
    inB     = b;
    inRm    = rm;
    inTag   = tag;
    accepted      = 1'b0;
    startAtAccept = 1'b0;
    waited        = 0;
    while (!accepted && waited < 200) begin
      accepted      = inReady;
      startAtAccept = divStart | sqrtStart;
      step(1);
      if (!accepted) waited++;
    end
    inValid = 1'b0;
    checkOutput("push_accept", accepted, 1'b1);
    if (accepted) begin
      m        = unitModel(op, a, b, rm);
      e.result = m[34:3];
      e.flags  = m[2:0];
      e.tag    = tag;
      expQ.push_back(e);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, inReady, 1'b1);
    checkOutput({tag, "_out_valid"}, outValid, 1'b0);
    checkOutput({tag, "_div_start"}, divStart, 1'b0);
    checkOutput({tag, "_sqrt_start"}, sqrtStart, 1'b0);
    checkOutput({tag, "_op_a"}, opA, 32'd0);
    checkOutput({tag, "_op_b"}, opB, 32'd0);
    checkOutput({tag, "_rm"}, rmOut, 3'd0);
    checkOutput({tag, "_result"}, outResult, 32'd0);
    checkOutput({tag, "_flags"}, outFlags, 3'd0);
    checkOutput({tag, "_tag"}, outTag, 4'd0);
  endtask

  // Unit model and output monitor both look at the DUT on the falling edge.
  always @(negedge clk) begin
    if (!rstN) begin
      modelBusy   = 1'b0;
      modelCnt    = 0;
      modelDone   = 1'b0;
      modelResult = 32'd0;
      {modelOf, modelUf, modelDz} = 3'b000;
      unitReady   = 1'b1;
    end else begin
      modelDone = 1'b0;
      if (modelBusy) begin
        checkOutput("start_while_busy", divStart | sqrtStart, 1'b0);
        checkOutput("op_a_stable", opA, latA);
        checkOutput("op_b_stable", opB, latB);
        checkOutput("rm_stable", rmOut, latRm);
        modelCnt--;
        if (modelCnt == 0) begin
          {modelResult, modelOf, modelUf, modelDz} = unitModel(latOp, latA, latB, latRm);
          modelDone = 1'b1;
          modelBusy = 1'b0;
        end
      end else if (divStart | sqrtStart) begin
        checkOutput("start_onehot", divStart & sqrtStart, 1'b0);
        latA      = opA;
        latB      = opB;
        latRm     = rmOut;
        latOp     = sqrtStart;
        modelBusy = 1'b1;
        modelCnt  = unitLatency;
        if (sqrtStart) sqrtStarts++;
        else divStarts++;
      end
      unitReady = !modelBusy;

      if (outValid && outReady) begin
        checkOutput("sb_pending", expQ.size() > 0, 1'b1);
        if (expQ.size() > 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("out_result", outResult, e.result);
          checkOutput("out_flags", outFlags, e.flags);
          checkOutput("out_tag", outTag, e.tag);
        end
      end
    end
  end

  initial begin
    int   waited, startsBefore;
    logic startAtAccept;
    inValid = 1'b0; inOp = 1'b0; inA = '0; inB = '0; inRm = '0; inTag = '0;
    outReady = 1'b0; lateDone = 1'b0; unitLatency = 12;
    divStarts = 0; sqrtStarts = 0; assertCount = 0; failCount = 0;
    modelDone = 1'b0; modelResult = '0; modelOf = 1'b0; modelUf = 1'b0; modelDz = 1'b0;
`ifdef DIV_SQRT_KILL_EN
    kill = 1'b0;
`endif
    step(3);
    checkResetOutputs("reset");
    rstN = 1'b1;
    step(2);

    $display("[TB] single divide");
    outReady = 1'b1;
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 3'd0, 4'd3, waited, startAtAccept);
    checkOutput("t1_no_early_start", divStart, 1'b0);
    step(1);
    checkOutput("t1_start_at_e2", divStart, 1'b1);
    step(1);
    checkOutput("t1_single_pulse", divStart, 1'b0);
    waitDrain(60);
    checkOutput("t1_div_starts", divStarts, 1);
    checkOutput("t1_sqrt_starts", sqrtStarts, 0);

    $display("[TB] flags: DZ, OF, UF");
    applyStimulus(1'b0, 32'h3F800000, 32'h00000000, 3'd0, 4'd5, waited, startAtAccept);
    applyStimulus(1'b0, 32'h7F000000, 32'h40000000, 3'd1, 4'd6, waited, startAtAccept);
    applyStimulus(1'b0, 32'h00800000, 32'h40000000, 3'd2, 4'd7, waited, startAtAccept);
    waitDrain(200);

    $display("[TB] back-to-back with full FIFO");
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 3'd0, 4'd0, waited, startAtAccept);
    applyStimulus(1'b1, 32'h40800000, 32'h00000000, 3'd3, 4'd1, waited, startAtAccept);
    applyStimulus(1'b0, 32'h40A00000, 32'h40000000, 3'd4, 4'd2, waited, startAtAccept);
    applyStimulus(1'b0, 32'hC1200000, 32'h3F000000, 3'd1, 4'd4, waited, startAtAccept);
    checkOutput("t3_stalled", waited > 0, 1'b1);
    checkOutput("t3_accept_after_pop", startAtAccept, 1'b1);
    waitDrain(300);

    $display("[TB] output backpressure");
    outReady = 1'b0;
    applyStimulus(1'b0, 32'h40000000, 32'h3F800000, 3'd0, 4'd8, waited, startAtAccept);
    applyStimulus(1'b0, 32'h40400000, 32'h40000000, 3'd0, 4'd9, waited, startAtAccept);
    waited = 0;
    while (!outValid && waited < 60) begin
      step(1);
      waited++;
    end
    checkOutput("t4_valid_seen", outValid, 1'b1);
    startsBefore = divStarts;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("t4_hold_valid", outValid, 1'b1);
      checkOutput("t4_hold_result", outResult, 32'h40000000);
      checkOutput("t4_hold_tag", outTag, 4'd8);
    end
    checkOutput("t4_no_second_start", divStarts, startsBefore);
    outReady = 1'b1;
    step(1);
    checkOutput("t4_issue_on_dequeue", divStart, 1'b1);
    waitDrain(100);

    $display("[TB] reset during busy");
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 3'd0, 4'd10, waited, startAtAccept);
    applyStimulus(1'b0, 32'h40A00000, 32'h3F800000, 3'd0, 4'd11, waited, startAtAccept);
    step(5);
    rstN = 1'b0;
    #1;
    checkResetOutputs("t5_reset");
    expQ.delete();
    startsBefore = divStarts + sqrtStarts;
    step(2);
    rstN = 1'b1;
    step(1);
    lateDone = 1'b1;
    step(1);
    lateDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("t5_no_out_valid", outValid, 1'b0);
    end
    checkOutput("t5_no_restart", divStarts + sqrtStarts, startsBefore);

`ifdef DIV_SQRT_KILL_EN
    $display("[TB] kill during busy");
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 3'd0, 4'd12, waited, startAtAccept);
    step(3);
    applyStimulus(1'b0, 32'h40A00000, 32'h3F800000, 3'd0, 4'd13, waited, startAtAccept);
    kill = 1'b1;
    #1;
    checkOutput("t6_ready_low_on_kill", inReady, 1'b0);
    step(1);
    kill = 1'b0;
    expQ.delete();
    startsBefore = divStarts + sqrtStarts;
    for (int i = 0; i < 30; i++) begin
      step(1);
      checkOutput("t6_no_out_valid", outValid, 1'b0);
    end
    checkOutput("t6_fifo_flushed", divStarts + sqrtStarts, startsBefore);
    applyStimulus(1'b1, 32'h40800000, 32'h00000000, 3'd0, 4'd14, waited, startAtAccept);
    waitDrain(60);
`endif

    checkOutput("final_sb_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
